// File: rtl/sdram_arb.sv
// Two-port arbiter in front of a single-port SDRAM controller; also owns the refresh timer.
// Define SDRAM_ARB_RR_EN for round-robin between the ports (default: fixed priority, p0 over p1).
module sdram_arb #(
    parameter int OP_CYCLES      = 12,
    parameter int REFRESH_CYCLES = 390
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        mem_ready_i,
    output logic        mem_rfsh_o,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic [21:0] mem_a_o,
    output logic [15:0] mem_d_o,
    input  logic [15:0] mem_q_i,
    input  logic        p0_req_i,
    input  logic [21:0] p0_a_i,
    output logic        p0_ack_o,
    output logic [15:0] p0_q_o,
    input  logic        p1_req_i,
    input  logic        p1_we_i,
    input  logic [21:0] p1_a_i,
    input  logic [15:0] p1_d_i,
    output logic        p1_ack_o,
    output logic [15:0] p1_q_o
);

    // state  | meaning
    // S_WAIT | after reset: wait for controller init and any in-flight op to drain
    // S_IDLE | arbitrate: refresh pending > port grant
    // S_OP   | port read/write in progress, address/data held
    // S_RFSH | refresh in progress
    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_OP   = 2'd2;
    localparam logic [1:0] S_RFSH = 2'd3;

    localparam int CNT_W = $clog2(OP_CYCLES);
    localparam int RC_W  = $clog2(REFRESH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OP_CYCLES - 1);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(REFRESH_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic             pend_q, pend_d;
    logic             port_q, port_d;
    logic             we_q, we_d;
    logic             mem_rd_q, mem_rd_d;
    logic             mem_wr_q, mem_wr_d;
    logic             mem_rfsh_q, mem_rfsh_d;
    logic [21:0]      mem_a_q, mem_a_d;
    logic [15:0]      mem_d_q, mem_d_d;
    logic             p0_ack_q, p0_ack_d;
    logic             p1_ack_q, p1_ack_d;
    logic [15:0]      p0_q_q, p0_q_d;
    logic [15:0]      p1_q_q, p1_q_d;
`ifdef SDRAM_ARB_RR_EN
    logic             last_q, last_d;
`endif

    logic req0, req1, grant0, grant1;

    // A request is ignored in its own ack cycle so a held level re-requests one cycle later.
    assign req0 = p0_req_i & ~p0_ack_q;
    assign req1 = p1_req_i & ~p1_ack_q;

`ifdef SDRAM_ARB_RR_EN
    // last_q=1: p1 was granted last, so p0 wins a tie.
    assign grant1 = req1 & (~req0 | ~last_q);
    assign grant0 = req0 & ~grant1;
`else
    assign grant0 = req0;
    assign grant1 = req1 & ~req0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rc_d       = rc_q;
        pend_d     = pend_q;
        port_d     = port_q;
        we_d       = we_q;
        mem_rd_d   = 1'b0;
        mem_wr_d   = 1'b0;
        mem_rfsh_d = 1'b1;
        mem_a_d    = mem_a_q;
        mem_d_d    = mem_d_q;
        p0_ack_d   = 1'b0;
        p1_ack_d   = 1'b0;
        p0_q_d     = p0_q_q;
        p1_q_d     = p1_q_q;
`ifdef SDRAM_ARB_RR_EN
        last_d     = last_q;
`endif

        case (state_q)
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (mem_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (pend_q) begin
                    state_d    = S_RFSH;
                    cnt_d      = CNT_LOAD;
                    pend_d     = 1'b0;
                    mem_rfsh_d = 1'b0;
                end else if (grant0) begin
                    state_d  = S_OP;
                    cnt_d    = CNT_LOAD;
                    port_d   = 1'b0;
                    we_d     = 1'b0;
                    mem_a_d  = p0_a_i;
                    mem_rd_d = 1'b1;
`ifdef SDRAM_ARB_RR_EN
                    last_d   = 1'b0;
`endif
                end else if (grant1) begin
                    state_d  = S_OP;
                    cnt_d    = CNT_LOAD;
                    port_d   = 1'b1;
                    we_d     = p1_we_i;
                    mem_a_d  = p1_a_i;
                    mem_d_d  = p1_d_i;
                    mem_rd_d = ~p1_we_i;
                    mem_wr_d = p1_we_i;
`ifdef SDRAM_ARB_RR_EN
                    last_d   = 1'b1;
`endif
                end
            end
            S_OP: begin
                // Strobe stays up for the first two op cycles only.
                if (cnt_q == CNT_LOAD) begin
                    mem_rd_d = mem_rd_q;
                    mem_wr_d = mem_wr_q;
                end
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    if (port_q) begin
                        p1_ack_d = 1'b1;
                        if (!we_q) begin
                            p1_q_d = mem_q_i;
                        end
                    end else begin
                        p0_ack_d = 1'b1;
                        p0_q_d   = mem_q_i;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RFSH: begin
                if (cnt_q == CNT_LOAD) begin
                    mem_rfsh_d = mem_rfsh_q;
                end
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_WAIT;
                cnt_d   = CNT_LOAD;
            end
        endcase

        // An expiry while already pending simply leaves pending set.
        if (state_q != S_WAIT) begin
            if (rc_q == RC_LAST) begin
                rc_d   = '0;
                pend_d = 1'b1;
            end else begin
                rc_d = rc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= S_WAIT;
            cnt_q      <= CNT_LOAD;
            rc_q       <= '0;
            pend_q     <= 1'b0;
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_rfsh_q <= 1'b1;
            mem_a_q    <= '0;
            mem_d_q    <= '0;
            p0_ack_q   <= 1'b0;
            p1_ack_q   <= 1'b0;
            p0_q_q     <= '0;
            p1_q_q     <= '0;
`ifdef SDRAM_ARB_RR_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rc_q       <= rc_d;
            pend_q     <= pend_d;
            port_q     <= port_d;
            we_q       <= we_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            mem_rfsh_q <= mem_rfsh_d;
            mem_a_q    <= mem_a_d;
            mem_d_q    <= mem_d_d;
            p0_ack_q   <= p0_ack_d;
            p1_ack_q   <= p1_ack_d;
            p0_q_q     <= p0_q_d;
            p1_q_q     <= p1_q_d;
`ifdef SDRAM_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    assign mem_rd_o   = mem_rd_q;
    assign mem_wr_o   = mem_wr_q;
    assign mem_rfsh_o = mem_rfsh_q;
    assign mem_a_o    = mem_a_q;
    assign mem_d_o    = mem_d_q;
    assign p0_ack_o   = p0_ack_q;
    assign p1_ack_o   = p1_ack_q;
    assign p0_q_o     = p0_q_q;
    assign p1_q_o     = p1_q_q;

endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb with a small edge-triggered SDRAM controller model.
module tb_sdram_arb;

    logic        clock = 1'b0;
    logic        reset_i = 1'b1;
    logic        mem_ready = 1'b0;
    logic        mem_rfsh_o, mem_rd_o, mem_wr_o;
    logic [21:0] mem_a_o;
    logic [15:0] mem_d_o;
    logic [15:0] mem_q = 16'h0000;
    logic        p0_req = 1'b0;
    logic [21:0] p0_a = '0;
    logic        p0_ack_o;
    logic [15:0] p0_q_o;
    logic        p1_req = 1'b0;
    logic        p1_we = 1'b0;
    logic [21:0] p1_a = '0;
    logic [15:0] p1_d = '0;
    logic        p1_ack_o;
    logic [15:0] p1_q_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clock = ~clock;

    sdram_arb #(.OP_CYCLES(12), .REFRESH_CYCLES(390)) dut (
        .clock_i    (clock),
        .reset_i    (reset_i),
        .mem_ready_i(mem_ready),
        .mem_rfsh_o (mem_rfsh_o),
        .mem_rd_o   (mem_rd_o),
        .mem_wr_o   (mem_wr_o),
        .mem_a_o    (mem_a_o),
        .mem_d_o    (mem_d_o),
        .mem_q_i    (mem_q),
        .p0_req_i   (p0_req),
        .p0_a_i     (p0_a),
        .p0_ack_o   (p0_ack_o),
        .p0_q_o     (p0_q_o),
        .p1_req_i   (p1_req),
        .p1_we_i    (p1_we),
        .p1_a_i     (p1_a),
        .p1_d_i     (p1_d),
        .p1_ack_o   (p1_ack_o),
        .p1_q_o     (p1_q_o)
    );

    // Controller model: unwritten locations read back as addr[15:0] ^ 16'h5A5A.
    logic [15:0]  mdata [256];
    logic [255:0] mvalid  = '0;
    logic         rd_prev = 1'b0;
    logic         wr_prev = 1'b0;

    always @(posedge clock) begin
        rd_prev <= mem_rd_o;
        wr_prev <= mem_wr_o;
        if (mem_wr_o && !wr_prev) begin
            mdata[mem_a_o[7:0]]  <= mem_d_o;
            mvalid[mem_a_o[7:0]] <= 1'b1;
        end
        if (mem_rd_o && !rd_prev) begin
            mem_q <= mvalid[mem_a_o[7:0]] ? mdata[mem_a_o[7:0]] : (mem_a_o[15:0] ^ 16'h5A5A);
        end
    end

    typedef struct packed {
        logic        port;
        logic        we;
        logic [21:0] a;
        logic [15:0] d;
        logic [15:0] exp_q;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_strobe(input int bound, output int at, output logic acked);
        logic done;
        at = -1;
        acked = 1'b0;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            tick();
            if (mem_rd_o || mem_wr_o) begin
                at = cyc;
                done = 1'b1;
            end else if (p0_ack_o || p1_ack_o) begin
                acked = 1'b1;
            end
        end
    endtask

    task automatic wait_ack(input int bound, output int at, output logic [1:0] which);
        logic done;
        at = -1;
        which = 2'b00;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            tick();
            if (p0_ack_o || p1_ack_o) begin
                at = cyc;
                which = {p1_ack_o, p0_ack_o};
                done = 1'b1;
            end
        end
    endtask

    // Wait for a refresh strobe, check its width, and return in the first idle cycle after it.
    task automatic sync_refresh(input string name, output int r);
        logic done;
        logic l1, l2;
        r = -1;
        done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            tick();
            if (!mem_rfsh_o) begin
                r = cyc;
                done = 1'b1;
            end
        end
        tick();
        l1 = mem_rfsh_o;
        tick();
        l2 = mem_rfsh_o;
        check({name, "_rfsh_found"}, 32'(r >= 0), 32'd1);
        check({name, "_rfsh_width"}, {30'd0, l2, l1}, 32'b10);
        while (cyc < r + 12) tick();
    endtask

    task automatic do_access(input int idx, input vec_t v);
        int          s;
        logic        ackd, a_ok, d_ok, early;
        logic [1:0]  kind, len, ack_bits;
        string       nm;
        nm = $sformatf("vec%0d", idx);
        if (v.port) begin
            p1_req = 1'b1; p1_we = v.we; p1_a = v.a; p1_d = v.d;
        end else begin
            p0_req = 1'b1; p0_a = v.a;
        end
        wait_strobe(60, s, ackd);
        kind  = {mem_wr_o, mem_rd_o};
        a_ok  = (mem_a_o == v.a);
        d_ok  = !v.we || (mem_d_o == v.d);
        early = 1'b0;
        len   = 2'b00;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 1) len[0] = mem_rd_o | mem_wr_o;
            if (k == 2) len[1] = mem_rd_o | mem_wr_o;
            if (k < 12) begin
                a_ok = a_ok && (mem_a_o == v.a);
                if (v.we) d_ok = d_ok && (mem_d_o == v.d);
                if (p0_ack_o || p1_ack_o) early = 1'b1;
            end
        end
        ack_bits = {p1_ack_o, p0_ack_o};
        p0_req = 1'b0;
        p1_req = 1'b0;
        check({nm, "_strobe_kind"}, {30'd0, kind}, v.we ? 32'b10 : 32'b01);
        check({nm, "_strobe_len"}, {30'd0, len}, 32'b01);
        check({nm, "_addr_stable"}, {31'd0, a_ok}, 32'd1);
        if (v.we) check({nm, "_data_stable"}, {31'd0, d_ok}, 32'd1);
        check({nm, "_early_ack"}, {31'd0, early}, 32'd0);
        check({nm, "_ack_at_n13"}, {30'd0, ack_bits}, v.port ? 32'b10 : 32'b01);
        check({nm, "_q"}, {16'd0, v.port ? p1_q_o : p0_q_o}, {16'd0, v.exp_q});
    endtask

    initial begin
        int          s, a, r, base, cnt;
        logic        ackd;
        logic [1:0]  w;
        logic [2:0]  pat;

        vecs[0] = '{port: 1'b1, we: 1'b1, a: 22'h012345, d: 16'hBEEF, exp_q: 16'h0000};
        vecs[1] = '{port: 1'b1, we: 1'b0, a: 22'h012345, d: 16'h0000, exp_q: 16'hBEEF};
        vecs[2] = '{port: 1'b0, we: 1'b0, a: 22'h012345, d: 16'h0000, exp_q: 16'hBEEF};
        vecs[3] = '{port: 1'b1, we: 1'b1, a: 22'h3FFFFF, d: 16'h1234, exp_q: 16'hBEEF};
        vecs[4] = '{port: 1'b0, we: 1'b0, a: 22'h3FFFFF, d: 16'h0000, exp_q: 16'h1234};
        vecs[5] = '{port: 1'b1, we: 1'b0, a: 22'h000F0F, d: 16'h0000, exp_q: 16'h5555};
        vecs[6] = '{port: 1'b0, we: 1'b0, a: 22'h000000, d: 16'h0000, exp_q: 16'h5A5A};

        // Reset values, then startup gating with mem_ready rising at cycle 3.
        repeat (3) @(posedge clock);
        #1;
        check("rst_strobes", {29'd0, mem_rfsh_o, mem_wr_o, mem_rd_o}, 32'b100);
        check("rst_addr", {10'd0, mem_a_o}, 32'd0);
        check("rst_data", {16'd0, mem_d_o}, 32'd0);
        check("rst_acks", {30'd0, p1_ack_o, p0_ack_o}, 32'd0);
        check("rst_q", {p1_q_o, p0_q_o}, 32'd0);
        reset_i = 1'b0;
        cyc = 0;
        p0_req = 1'b1;
        p0_a = 22'h000AAA;
        repeat (3) tick();
        mem_ready = 1'b1;
        wait_strobe(40, s, ackd);
        check("t1_first_strobe_cycle", s, 32'd13);
        check("t1_first_strobe_kind", {30'd0, mem_wr_o, mem_rd_o}, 32'b01);
        wait_ack(20, a, w);
        p0_req = 1'b0;
        check("t1_ack_cycle", a, 32'd25);
        check("t1_ack_port", {30'd0, w}, 32'b01);
        check("t1_p0_q", {16'd0, p0_q_o}, 32'h50F0);
        sync_refresh("t1", r);
        check("t1_first_rfsh_cycle", r, 32'd403);

        for (int i = 0; i < 7; i++) do_access(i, vecs[i]);

        // Simultaneous requests.
        sync_refresh("t3", r);
        base = cyc;
        p0_req = 1'b1; p0_a = 22'h3FFFFF;
        p1_req = 1'b1; p1_we = 1'b0; p1_a = 22'h012345;
        wait_strobe(20, s, ackd);
        check("t3_first_strobe", s - base, 32'd1);
        wait_ack(20, a, w);
        check("t3_first_ack_cycle", a - base, 32'd13);
`ifdef SDRAM_ARB_RR_EN
        check("t3_first_ack_port", {30'd0, w}, 32'b10);
        p1_req = 1'b0;
`else
        check("t3_first_ack_port", {30'd0, w}, 32'b01);
        p0_req = 1'b0;
`endif
        wait_strobe(20, s, ackd);
        check("t3_second_strobe", s - base, 32'd14);
        wait_ack(20, a, w);
        p0_req = 1'b0;
        p1_req = 1'b0;
        check("t3_second_ack_cycle", a - base, 32'd26);
`ifdef SDRAM_ARB_RR_EN
        check("t3_second_ack_port", {30'd0, w}, 32'b01);
`else
        check("t3_second_ack_port", {30'd0, w}, 32'b10);
`endif
        check("t3_q", {p1_q_o, p0_q_o}, 32'hBEEF1234);

        // Refresh expiry in the middle of a p1 write, p0 queued behind it.
        sync_refresh("t4", r);
        while (cyc < r + 383) tick();
        base = cyc;
        p1_req = 1'b1; p1_we = 1'b1; p1_a = 22'h000ABC; p1_d = 16'h0C0C;
        wait_strobe(20, s, ackd);
        check("t4_p1_strobe", s - base, 32'd1);
        p0_req = 1'b1; p0_a = 22'h000F0F;
        wait_ack(20, a, w);
        p1_req = 1'b0;
        check("t4_p1_ack_cycle", a - base, 32'd13);
        check("t4_p1_ack_port", {30'd0, w}, 32'b10);
        tick(); pat[0] = mem_rfsh_o;
        tick(); pat[1] = mem_rfsh_o;
        tick(); pat[2] = mem_rfsh_o;
        check("t4_rfsh_after_ack", {29'd0, pat}, 32'b100);
        wait_strobe(20, s, ackd);
        check("t4_p0_strobe", s - base, 32'd27);
        wait_ack(20, a, w);
        p0_req = 1'b0;
        check("t4_p0_ack_cycle", a - base, 32'd39);
        check("t4_p0_q", {16'd0, p0_q_o}, 32'h5555);

        // Held request re-grants one cycle after ack; a withdrawn request never runs.
        sync_refresh("t6", r);
        base = cyc;
        p1_req = 1'b1; p1_we = 1'b0; p1_a = 22'h012345;
        wait_strobe(20, s, ackd);
        check("t6_strobe1", s - base, 32'd1);
        wait_ack(20, a, w);
        check("t6_ack1", a - base, 32'd13);
        wait_strobe(20, s, ackd);
        check("t6_strobe2", s - base, 32'd15);
        wait_ack(20, a, w);
        p1_req = 1'b0;
        check("t6_ack2", a - base, 32'd27);
        tick();
        base = cyc;
        p0_req = 1'b1; p0_a = 22'h000000;
        repeat (3) tick();
        p1_req = 1'b1; p1_we = 1'b1; p1_a = 22'h000055; p1_d = 16'hDEAD;
        repeat (3) tick();
        p1_req = 1'b0;
        wait_ack(20, a, w);
        p0_req = 1'b0;
        check("t6_p0_ack_cycle", a - base, 32'd13);
        check("t6_p0_ack_port", {30'd0, w}, 32'b01);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_rd_o || mem_wr_o || p0_ack_o || p1_ack_o) cnt++;
        end
        check("t6_withdrawn_activity", cnt, 32'd0);
        check("t6_q", {p1_q_o, p0_q_o}, 32'hBEEF5A5A);

        // Reset in the middle of a p1 read.
        sync_refresh("t5", r);
        base = cyc;
        p1_req = 1'b1; p1_we = 1'b0; p1_a = 22'h000AAA;
        repeat (4) tick();
        check("t5_addr_before_reset", {10'd0, mem_a_o}, 32'h000AAA);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("t5_rst_strobes", {29'd0, mem_rfsh_o, mem_wr_o, mem_rd_o}, 32'b100);
        check("t5_rst_addr", {10'd0, mem_a_o}, 32'd0);
        check("t5_rst_acks", {30'd0, p1_ack_o, p0_ack_o}, 32'd0);
        check("t5_rst_q", {p1_q_o, p0_q_o}, 32'd0);
        wait_strobe(40, s, ackd);
        check("t5_regrant_strobe", s - base, 32'd18);
        check("t5_no_ack_before_regrant", {31'd0, ackd}, 32'd0);
        wait_ack(20, a, w);
        p1_req = 1'b0;
        check("t5_ack_cycle", a - base, 32'd30);
        check("t5_ack_port", {30'd0, w}, 32'b10);
        check("t5_p1_q", {16'd0, p1_q_o}, 32'h50F0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
